pipe_hazard_unit: RTL and testbench
===================================

Name: pipe_hazard_unit

Overview:
- Parametrised hazard and forwarding controller for the IF/DE/MW RISC-V pipeline.
- Tracks the instruction in MW using an internal shadow register, and forwards MW write-back data to the DE operands.
- Stalls the pipe when DE needs MW data that is not yet valid, for example a multi-cycle data memory.
- Generates a configurable-length IF flush after a taken branch or jump resolved in DE, and flags stalls that exceed a watchdog limit.

Parameters:
XLEN, 32, data width of operands and write-back data
NREG, 32, architectural register count; register 0 is hardwired zero
BR_FLUSH, 1, cycles flush_o stays asserted per taken branch (>=1)
MAX_STALL, 255, consecutive stall cycles before err_o sets (>=1)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
de_valid_i  in  1  DE holds a real instruction
de_rs1_i  in  $clog2(NREG)  DE source 1 address
de_rs2_i  in  $clog2(NREG)  DE source 2 address
de_use_rs1_i  in  1  DE instruction reads rs1
de_use_rs2_i  in  1  DE instruction reads rs2
de_rd_i  in  $clog2(NREG)  DE destination
de_we_i  in  1  DE instruction writes rd
de_br_taken_i  in  1  DE branch/jump taken this cycle
rs1_rf_i  in  XLEN  register-file rs1 read data
rs2_rf_i  in  XLEN  register-file rs2 read data
mw_wb_data_i  in  XLEN  MW write-back data (selected wb_data)
mw_wb_valid_i  in  1  mw_wb_data_i valid this cycle
rs1_o  out  XLEN  forwarded rs1 operand
rs2_o  out  XLEN  forwarded rs2 operand
fwd1_o  out  1  rs1_o taken from MW
fwd2_o  out  1  rs2_o taken from MW
stall_o  out  1  hold PC, IF, DE and MW registers
flush_o  out  1  load NOP into IF/DE register
err_o  out  1  sticky stall watchdog error
state_o  out  2  00 RUN, 01 STALL, 10 FLUSH

Behaviour:
- Reset (async, rst_i=1):
  - MW shadow is cleared: mw_v=0, mw_we=0, mw_rd=0.
  - State is RUN; stall counter and flush counter are 0; err_o=0.
  - Outputs: stall_o=0, flush_o=0, fwd1_o=0, fwd2_o=0, state_o=00.
  - rs1_o and rs2_o pass through the register-file data, since the shadow is empty.
- Reset asserted mid-stall or mid-flush: all state is dropped immediately.
- MW shadow update:
  - Captures {de_valid_i, de_we_i, de_rd_i} on each clock edge where stall_o=0.
  - Holds its value while stall_o=1.
- Match condition, per source x in {1,2}: matchx = de_valid_i & de_use_rsx_i & mw_v & mw_we & (mw_rd != 0) & (mw_rd == de_rsx_i).
- Forwarding (combinational):
  - If matchx & mw_wb_valid_i: rsx_o = mw_wb_data_i and fwdx_o=1.
  - Otherwise: rsx_o = register-file data and fwdx_o=0.
  - Register 0 is never forwarded.
- Hazard: hz = (match1 | match2) & !mw_wb_valid_i.
- stall_o = hz. It is combinational, so it drops in the same cycle mw_wb_valid_i rises; that cycle forwards and the pipe advances.
- Branch priority: a branch seen while hz=1 is ignored, because its operands are not final.
- Taken-branch trigger: de_br_taken_i & de_valid_i & !hz.
- flush_o = trigger | (state==FLUSH).
- State machine:
  - RUN: if hz, go to STALL. Else if trigger and BR_FLUSH>1, go to FLUSH with flush count = BR_FLUSH-1. Otherwise stay in RUN.
  - STALL: the stall count increments each cycle with hz=1 and saturates at MAX_STALL.
    - When the count reaches MAX_STALL, err_o goes to 1 and stays set until reset.
    - When hz falls, the count clears and the state returns to RUN. If a trigger occurs in that same cycle, the RUN branch rules apply.
  - FLUSH: the flush count decrements each cycle; when it reaches 1, go to RUN.
    - de_valid_i is 0 during FLUSH because IF/DE holds a NOP, so hz cannot occur.
    - A new trigger in FLUSH reloads the count to BR_FLUSH-1.
- Timing: forwarding adds zero latency, and each stall lasts exactly as many cycles as mw_wb_valid_i stays low.

Test Plan:
- Reset: assert rst_i mid-STALL with the stall count at 5 -> immediately stall_o=0, state_o=00, err_o=0; the next dependent instruction is not forwarded from the stale shadow.
- ALU back-to-back: addi x5 is in MW with mw_wb_valid_i=1 and data 0x0000_0010; DE is add x6,x5,x5 -> fwd1_o=fwd2_o=1, rs1_o=rs2_o=0x10, stall_o=0.
- x0 guard: MW writes x0 with data 0xDEAD_BEEF; DE reads x0, and rs1_rf_i=0 -> rs1_o=0, fwd1_o=0.
- Multi-cycle load: lw x7 is in MW with mw_wb_valid_i low for 3 cycles; DE uses x7 -> stall_o=1 for exactly 3 cycles and state_o=01. On the 4th cycle, rs1_o=mw_wb_data_i (0x1234_5678) and stall_o=0.
- Branch flush with BR_FLUSH=3: a taken branch in DE with no hazard -> flush_o=1 for 3 consecutive cycles, then RUN. Repeat while a hazard is present -> no flush until the stall clears.
- Watchdog with MAX_STALL=4: a dependent DE instruction with mw_wb_valid_i held low -> err_o rises after 4 stall cycles and stays 1 after the stall releases.

Source files
------------

// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller for the IF/DE/MW pipeline: shadows the MW
// instruction, forwards MW write-back into DE operands, stalls and flushes.

module pipe_hazard_unit_lane #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            valid,
  input  logic            use_rs,
  input  logic [AW-1:0]   rs,
  input  logic            mw_hit,
  input  logic [AW-1:0]   mw_rd,
  input  logic            wb_valid,
  input  logic [XLEN-1:0] wb_data,
  input  logic [XLEN-1:0] rf_data,
  output logic            hit,
  output logic            fwd,
  output logic [XLEN-1:0] data
);
  assign hit  = valid & use_rs & mw_hit & (mw_rd == rs);
  assign fwd  = hit & wb_valid;
  assign data = fwd ? wb_data : rf_data;
endmodule

module pipe_hazard_unit #(
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter int BR_FLUSH  = 1,
  parameter int MAX_STALL = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    de_valid_i,
  input  logic [$clog2(NREG)-1:0] de_rs1_i,
  input  logic [$clog2(NREG)-1:0] de_rs2_i,
  input  logic                    de_use_rs1_i,
  input  logic                    de_use_rs2_i,
  input  logic [$clog2(NREG)-1:0] de_rd_i,
  input  logic                    de_we_i,
  input  logic                    de_br_taken_i,
  input  logic [XLEN-1:0]         rs1_rf_i,
  input  logic [XLEN-1:0]         rs2_rf_i,
  input  logic [XLEN-1:0]         mw_wb_data_i,
  input  logic                    mw_wb_valid_i,
  output logic [XLEN-1:0]         rs1_o,
  output logic [XLEN-1:0]         rs2_o,
  output logic                    fwd1_o,
  output logic                    fwd2_o,
  output logic                    stall_o,
  output logic                    flush_o,
  output logic                    err_o,
  output logic [1:0]              state_o
);
  localparam int AW = $clog2(NREG);
  localparam int SW = $clog2(MAX_STALL + 1);
  localparam int FW = (BR_FLUSH > 1) ? $clog2(BR_FLUSH) : 1;
  localparam logic [SW-1:0] SMAX  = SW'(MAX_STALL);
  localparam logic [FW-1:0] FLOAD = FW'(BR_FLUSH - 1);

  typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, FLUSH = 2'b10} state_t;

  state_t        state, state_n;
  logic [SW-1:0] scnt, scnt_n;
  logic [FW-1:0] fcnt, fcnt_n;
  logic          err_n;

  logic          mw_v, mw_we;
  logic [AW-1:0] mw_rd;
  logic          mw_hit, hz, trig;

  logic [1:0][AW-1:0]   rs;
  logic [1:0]           use_rs, hit, fwd;
  logic [1:0][XLEN-1:0] rf, opnd;

  assign rs     = {de_rs2_i, de_rs1_i};
  assign use_rs = {de_use_rs2_i, de_use_rs1_i};
  assign rf     = {rs2_rf_i, rs1_rf_i};
  // x0 writes never count as producers, so x0 is never forwarded or stalled on
  assign mw_hit = mw_v & mw_we & (mw_rd != '0);

  for (genvar i = 0; i < 2; i++) begin : g_src
    pipe_hazard_unit_lane #(.XLEN(XLEN), .AW(AW)) u_lane (
      .valid   (de_valid_i),
      .use_rs  (use_rs[i]),
      .rs      (rs[i]),
      .mw_hit  (mw_hit),
      .mw_rd   (mw_rd),
      .wb_valid(mw_wb_valid_i),
      .wb_data (mw_wb_data_i),
      .rf_data (rf[i]),
      .hit     (hit[i]),
      .fwd     (fwd[i]),
      .data    (opnd[i])
    );
  end

  assign rs1_o   = opnd[0];
  assign rs2_o   = opnd[1];
  assign fwd1_o  = fwd[0];
  assign fwd2_o  = fwd[1];
  assign hz      = (|hit) & ~mw_wb_valid_i;
  // a branch resolved on stale operands is ignored until the stall clears
  assign trig    = de_br_taken_i & de_valid_i & ~hz;
  assign stall_o = hz;
  assign flush_o = trig | (state == FLUSH);
  assign state_o = state;

  always_comb begin
    state_n = state;
    scnt_n  = scnt;
    fcnt_n  = fcnt;
    if (hz) begin
      state_n = STALL;
      fcnt_n  = '0;
      scnt_n  = (scnt == SMAX) ? scnt : scnt + 1'b1;
    end else begin
      scnt_n = '0;
      if (trig) begin
        if (BR_FLUSH > 1) begin
          state_n = FLUSH;
          fcnt_n  = FLOAD;
        end else begin
          state_n = RUN;
          fcnt_n  = '0;
        end
      end else if (state == FLUSH) begin
        if (fcnt <= FW'(1)) begin
          state_n = RUN;
          fcnt_n  = '0;
        end else begin
          fcnt_n = fcnt - 1'b1;
        end
      end else begin
        state_n = RUN;
      end
    end
    err_n = err_o | (scnt_n == SMAX);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= RUN;
      scnt  <= '0;
      fcnt  <= '0;
      err_o <= 1'b0;
    end else begin
      state <= state_n;
      scnt  <= scnt_n;
      fcnt  <= fcnt_n;
      err_o <= err_n;
    end
  end

  // shadow of the instruction now in MW; frozen with the rest of the pipe
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mw_v  <= 1'b0;
      mw_we <= 1'b0;
      mw_rd <= '0;
    end else if (!hz) begin
      mw_v  <= de_valid_i;
      mw_we <= de_we_i;
      mw_rd <= de_rd_i;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: vector table, hand sequences for stall/flush/
// watchdog/reset, then random traffic against a cycle-level reference model.

module tb_pipe_hazard_unit;
  localparam int XLEN = 32, NREG = 32, BRF = 3, MAXS = 4;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            de_valid_i, de_use_rs1_i, de_use_rs2_i, de_we_i, de_br_taken_i;
  logic [4:0]      de_rs1_i, de_rs2_i, de_rd_i;
  logic [XLEN-1:0] rs1_rf_i, rs2_rf_i, mw_wb_data_i;
  logic            mw_wb_valid_i;
  logic [XLEN-1:0] rs1_o, rs2_o;
  logic            fwd1_o, fwd2_o, stall_o, flush_o, err_o;
  logic [1:0]      state_o;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_hazard_unit #(.XLEN(XLEN), .NREG(NREG), .BR_FLUSH(BRF), .MAX_STALL(MAXS)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .de_valid_i(de_valid_i), .de_rs1_i(de_rs1_i),
    .de_rs2_i(de_rs2_i), .de_use_rs1_i(de_use_rs1_i), .de_use_rs2_i(de_use_rs2_i),
    .de_rd_i(de_rd_i), .de_we_i(de_we_i), .de_br_taken_i(de_br_taken_i),
    .rs1_rf_i(rs1_rf_i), .rs2_rf_i(rs2_rf_i), .mw_wb_data_i(mw_wb_data_i),
    .mw_wb_valid_i(mw_wb_valid_i), .rs1_o(rs1_o), .rs2_o(rs2_o), .fwd1_o(fwd1_o),
    .fwd2_o(fwd2_o), .stall_o(stall_o), .flush_o(flush_o), .err_o(err_o),
    .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        mw_we;
    logic [4:0]  mw_rd, rs1, rs2;
    logic        u1, u2, wbv;
    logic [31:0] wbd, rf1, rf2;
    logic [31:0] e_rs1, e_rs2;
    logic        e_f1, e_f2, e_st;
  } vec_t;
  vec_t vt [8];

  // reference model state: MW shadow, consecutive stall cycles, FLUSH cycles left
  bit         mv, mwe, merr;
  logic [4:0] mrd;
  int         srun, fleft;
  bit         mhz, mtrig;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    de_valid_i = 0; de_use_rs1_i = 0; de_use_rs2_i = 0; de_we_i = 0; de_br_taken_i = 0;
    de_rs1_i = 0; de_rs2_i = 0; de_rd_i = 0;
    rs1_rf_i = 32'hA5A5_A5A5; rs2_rf_i = 32'h5A5A_5A5A;
    mw_wb_data_i = 0; mw_wb_valid_i = 0;
  endtask

  task automatic model_reset();
    mv = 0; mwe = 0; mrd = 0; srun = 0; fleft = 0; merr = 0;
  endtask

  task automatic do_reset();
    rst_i = 1; idle();
    @(posedge clk_i); #1;
    rst_i = 0; model_reset();
  endtask

  task automatic next_cycle();
    @(posedge clk_i); #1;
  endtask

  task automatic load_shadow(input logic we, input logic [4:0] rd);
    idle(); de_valid_i = 1; de_we_i = we; de_rd_i = rd;
    next_cycle();
  endtask

  // DE instruction reading rs1=x7, as used by the multi-cycle sequences
  task automatic dep_x7(input logic wbv, input logic [31:0] wbd);
    idle(); de_valid_i = 1; de_rs1_i = 7; de_use_rs1_i = 1;
    rs1_rf_i = 32'h0000_0BAD; mw_wb_valid_i = wbv; mw_wb_data_i = wbd;
  endtask

  task automatic model_check();
    bit m1, m2, f1, f2;
    int est;
    m1 = de_valid_i && de_use_rs1_i && mv && mwe && mrd != 0 && mrd == de_rs1_i;
    m2 = de_valid_i && de_use_rs2_i && mv && mwe && mrd != 0 && mrd == de_rs2_i;
    f1 = m1 && mw_wb_valid_i;
    f2 = m2 && mw_wb_valid_i;
    mhz   = (m1 || m2) && !mw_wb_valid_i;
    mtrig = de_br_taken_i && de_valid_i && !mhz;
    est = (srun > 0) ? 1 : (fleft > 0) ? 2 : 0;
    chk("rnd_rs1", rs1_o, f1 ? mw_wb_data_i : rs1_rf_i);
    chk("rnd_rs2", rs2_o, f2 ? mw_wb_data_i : rs2_rf_i);
    chk("rnd_fwd1", fwd1_o, f1);
    chk("rnd_fwd2", fwd2_o, f2);
    chk("rnd_stall", stall_o, mhz);
    chk("rnd_flush", flush_o, mtrig || fleft > 0);
    chk("rnd_state", state_o, est);
    chk("rnd_err", err_o, merr);
  endtask

  task automatic model_advance();
    if (!mhz) begin mv = de_valid_i; mwe = de_we_i; mrd = de_rd_i; end
    if (mhz) begin
      srun  = (srun < MAXS) ? srun + 1 : MAXS;
      fleft = 0;
    end else begin
      srun  = 0;
      fleft = mtrig ? BRF - 1 : (fleft > 0 ? fleft - 1 : 0);
    end
    if (srun >= MAXS) merr = 1;
  endtask

  initial begin
    vt[0] = '{1, 5, 5, 5, 1, 1, 1, 32'h10, 32'h111, 32'h222, 32'h10, 32'h10, 1, 1, 0};
    vt[1] = '{1, 0, 0, 0, 1, 0, 1, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0};
    vt[2] = '{1, 3, 4, 3, 1, 1, 1, 32'hCAFE, 32'h1, 32'h2, 32'h1, 32'hCAFE, 0, 1, 0};
    vt[3] = '{1, 3, 3, 3, 0, 0, 1, 32'hCAFE, 32'h1, 32'h2, 32'h1, 32'h2, 0, 0, 0};
    vt[4] = '{0, 3, 3, 3, 1, 1, 1, 32'hCAFE, 32'h1, 32'h2, 32'h1, 32'h2, 0, 0, 0};
    vt[5] = '{1, 9, 9, 2, 1, 1, 0, 32'h77, 32'h3, 32'h4, 32'h3, 32'h4, 0, 0, 1};
    vt[6] = '{1, 9, 1, 9, 1, 1, 0, 32'h77, 32'h3, 32'h4, 32'h3, 32'h4, 0, 0, 1};
    vt[7] = '{1, 9, 8, 8, 1, 1, 0, 32'h77, 32'h3, 32'h4, 32'h3, 32'h4, 0, 0, 0};

    idle();
    repeat (2) @(posedge clk_i);
    #1; rst_i = 0; model_reset();
    do_reset();

    // reset state
    @(negedge clk_i);
    chk("rst_stall", stall_o, 0); chk("rst_flush", flush_o, 0);
    chk("rst_fwd1", fwd1_o, 0);   chk("rst_fwd2", fwd2_o, 0);
    chk("rst_state", state_o, 0); chk("rst_err", err_o, 0);
    chk("rst_rs1", rs1_o, 32'hA5A5_A5A5); chk("rst_rs2", rs2_o, 32'h5A5A_5A5A);

    // forwarding / hazard vector table
    for (int i = 0; i < 8; i++) begin
      do_reset();
      load_shadow(vt[i].mw_we, vt[i].mw_rd);
      idle(); de_valid_i = 1;
      de_rs1_i = vt[i].rs1; de_rs2_i = vt[i].rs2;
      de_use_rs1_i = vt[i].u1; de_use_rs2_i = vt[i].u2;
      mw_wb_valid_i = vt[i].wbv; mw_wb_data_i = vt[i].wbd;
      rs1_rf_i = vt[i].rf1; rs2_rf_i = vt[i].rf2;
      @(negedge clk_i);
      chk($sformatf("vec%0d_rs1", i), rs1_o, vt[i].e_rs1);
      chk($sformatf("vec%0d_rs2", i), rs2_o, vt[i].e_rs2);
      chk($sformatf("vec%0d_fwd1", i), fwd1_o, vt[i].e_f1);
      chk($sformatf("vec%0d_fwd2", i), fwd2_o, vt[i].e_f2);
      chk($sformatf("vec%0d_stall", i), stall_o, vt[i].e_st);
    end

    // multi-cycle load: three stall cycles, then forward on the fourth
    do_reset(); load_shadow(1, 7);
    for (int c = 0; c < 3; c++) begin
      dep_x7(0, 32'h0);
      @(negedge clk_i);
      chk("ld_stall", stall_o, 1);
      chk("ld_state", state_o, (c == 0) ? 0 : 1);
      next_cycle();
    end
    dep_x7(1, 32'h1234_5678);
    @(negedge clk_i);
    chk("ld_stall_rel", stall_o, 0); chk("ld_rs1", rs1_o, 32'h1234_5678);
    chk("ld_fwd1", fwd1_o, 1);       chk("ld_err", err_o, 0);
    next_cycle(); idle();
    @(negedge clk_i);
    chk("ld_state_run", state_o, 0);

    // taken branch, no hazard: three flush cycles
    do_reset();
    idle(); de_valid_i = 1; de_br_taken_i = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      chk("br_flush", flush_o, c < 3);
      chk("br_state", state_o, (c == 1 || c == 2) ? 2 : 0);
      next_cycle(); idle();
    end

    // taken branch behind a hazard: flush only once the stall clears
    do_reset(); load_shadow(1, 7);
    for (int c = 0; c < 3; c++) begin
      dep_x7(c == 2, 32'h99); de_br_taken_i = 1;
      @(negedge clk_i);
      chk("brhz_stall", stall_o, c < 2);
      chk("brhz_flush", flush_o, c == 2);
      next_cycle();
    end
    for (int c = 0; c < 3; c++) begin
      idle();
      @(negedge clk_i);
      chk("brhz_tail_flush", flush_o, c < 2);
      chk("brhz_tail_state", state_o, (c < 2) ? 2 : 0);
      next_cycle();
    end

    // watchdog: err after MAXS stall cycles, sticky past release
    do_reset(); load_shadow(1, 7);
    for (int c = 0; c < 6; c++) begin
      dep_x7(0, 32'h0);
      @(negedge clk_i);
      chk("wd_err", err_o, c >= MAXS);
      chk("wd_stall", stall_o, 1);
      next_cycle();
    end
    dep_x7(1, 32'h42);
    @(negedge clk_i);
    chk("wd_rel_stall", stall_o, 0); chk("wd_rel_err", err_o, 1);
    next_cycle(); idle(); next_cycle();
    @(negedge clk_i);
    chk("wd_sticky", err_o, 1);

    // reset in the middle of a stall
    do_reset(); load_shadow(1, 7);
    for (int c = 0; c < 5; c++) begin dep_x7(0, 32'h0); next_cycle(); end
    #2 rst_i = 1;
    #1;
    chk("mrst_stall", stall_o, 0); chk("mrst_state", state_o, 0); chk("mrst_err", err_o, 0);
    next_cycle(); rst_i = 0; model_reset();
    dep_x7(1, 32'h55);
    @(negedge clk_i);
    chk("mrst_fwd1", fwd1_o, 0); chk("mrst_rs1", rs1_o, 32'h0000_0BAD);

    // random traffic against the reference model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (n % 150 == 149) do_reset();
      de_valid_i    = (fleft > 0) ? 1'b0 : 1'($urandom_range(0, 3) != 0);
      de_rs1_i      = 5'($urandom_range(0, 3));
      de_rs2_i      = 5'($urandom_range(0, 3));
      de_rd_i       = 5'($urandom_range(0, 3));
      de_use_rs1_i  = 1'($urandom);
      de_use_rs2_i  = 1'($urandom);
      de_we_i       = 1'($urandom);
      de_br_taken_i = 1'($urandom_range(0, 4) == 0);
      mw_wb_valid_i = 1'($urandom_range(0, 2) != 0);
      mw_wb_data_i  = $urandom;
      rs1_rf_i      = $urandom;
      rs2_rf_i      = $urandom;
      @(negedge clk_i);
      model_check();
      @(posedge clk_i);
      model_advance();
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
